// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and helpers: key modes, Nk/Nr lookups, xtime, word typedefs.
package aes_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned NUM_WORDS = 60;
  localparam int unsigned NUM_RK    = 15;
  localparam int unsigned KEY_W     = 256;

  typedef enum logic [1:0] {
    MODE_128  = 2'd0,
    MODE_192  = 2'd1,
    MODE_256  = 2'd2,
    MODE_RSVD = 2'd3
  } key_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [4*WORD_W-1:0]     round_key_t;
  typedef round_key_t [NUM_RK-1:0] round_keys_t;

  function automatic logic [3:0] nk_of(input key_mode_e m);
    case (m)
      MODE_128: return 4'd4;
      MODE_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input key_mode_e m);
    case (m)
      MODE_128: return 4'd10;
      MODE_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  function automatic int unsigned key_bits(input key_mode_e m);
    return 32 * int'(nk_of(m));
  endfunction

  // GF(2^8) doubling, reduction polynomial 0x11b
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/sub_word.sv
// Four parallel AES S-box lookups on a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  word_t src,
  output word_t res
);

  // byte x sits at bits [8*(255-x)+7 -: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  assign res = {sbox(src[31:24]), sbox(src[23:16]), sbox(src[15:8]), sbox(src[7:0])};

endmodule

// File: rtl/key_schedule_rt.sv
// Run-time AES-128/192/256 key expansion, one schedule word per cycle, result held until taken.
module key_schedule_rt
  import aes_pkg::*;
#(
  parameter int unsigned MAX_KEY_SIZE = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [1:0]   mode_i,
  input  logic [255:0] key_i,
  output logic         valid_o,
  input  logic         ready_i,
  output round_keys_t  round_key_o,
  output logic [3:0]   nr_o,
  output logic         err_o
);

  ks_state_e state_q, state_d;
  key_mode_e mode_q;
  logic [5:0] idx_q;
  logic [2:0] pos_q;
  logic [7:0] rcon_q;
  word_t      w_q [NUM_WORDS];

  logic       accept_c, reject_c, bad_c, last_c;
  logic [3:0] nk_c;
  word_t      prev_c, back_c, sub_in_c, sub_out_c, temp_c, new_word_c;

  assign bad_c  = (key_mode_e'(mode_i) == MODE_RSVD) ||
                  (key_bits(key_mode_e'(mode_i)) > MAX_KEY_SIZE);
  assign nk_c   = nk_of(mode_q);
  assign last_c = (idx_q == {nr_of(mode_q), 2'b11});

  // pos_q tracks i mod Nk so no divider is needed for the 192-bit case
  assign prev_c   = w_q[idx_q - 6'd1];
  assign back_c   = w_q[idx_q - 6'(nk_c)];
  assign sub_in_c = (pos_q == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;

  sub_word u_sub_word (
    .src (sub_in_c),
    .res (sub_out_c)
  );

  always_comb begin
    temp_c = prev_c;
    if (pos_q == 3'd0) begin
      temp_c = sub_out_c ^ {rcon_q, 24'h0};
    end else if (nk_c == 4'd8 && pos_q == 3'd4) begin
      temp_c = sub_out_c;
    end
    new_word_c = back_c ^ temp_c;
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    reject_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (bad_c) begin
            reject_c = 1'b1;
          end else begin
            accept_c = 1'b1;
            state_d  = EXPAND;
          end
        end
      end
      EXPAND:  if (last_c) state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_o <= (state_d == IDLE);
      valid_o <= (state_d == DONE);
      err_o   <= reject_c;
    end
  end

  // Key-word array, index and Rcon; acceptance reloads the key and clears every other word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_128;
      idx_q  <= 6'd0;
      pos_q  <= 3'd0;
      rcon_q <= 8'h00;
      nr_o   <= 4'd0;
      for (int k = 0; k < NUM_WORDS; k++) w_q[k] <= '0;
    end else if (accept_c) begin
      mode_q <= key_mode_e'(mode_i);
      idx_q  <= 6'(nk_of(key_mode_e'(mode_i)));
      pos_q  <= 3'd0;
      rcon_q <= 8'h01;
      nr_o   <= nr_of(key_mode_e'(mode_i));
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (k < int'(nk_of(key_mode_e'(mode_i)))) w_q[k] <= key_i[KEY_W-1-32*k -: 32];
        else                                       w_q[k] <= '0;
      end
    end else if (state_q == EXPAND) begin
      w_q[idx_q] <= new_word_c;
      if (!last_c) idx_q <= idx_q + 6'd1;
      pos_q <= (pos_q == 3'(nk_c - 4'd1)) ? 3'd0 : pos_q + 3'd1;
      if (pos_q == 3'd0) rcon_q <= xtime(rcon_q);
    end
  end

  always_comb begin
    for (int j = 0; j < NUM_RK; j++) begin
      round_key_o[j] = {w_q[4*j], w_q[4*j+1], w_q[4*j+2], w_q[4*j+3]};
    end
  end

endmodule

// File: tb/tb_key_schedule_rt.sv
// Self-checking bench for key_schedule_rt against a FIPS-197 reference with a computed S-box.
module tb_key_schedule_rt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               valid_i = 1'b0, ready_i = 1'b0;
  logic [1:0]         mode_i = 2'd0;
  logic [255:0]       key_i = '0;
  logic               ready_o, valid_o, err_o;
  logic [14:0][127:0] round_key_o;
  logic [3:0]         nr_o;

  logic               b_valid = 1'b0, b_ready_i = 1'b0;
  logic [1:0]         b_mode = 2'd0;
  logic [255:0]       b_key = '0;
  logic               b_ready, b_valid_o, b_err;
  logic [14:0][127:0] b_rk;
  logic [3:0]         b_nr;

  key_schedule_rt #(.MAX_KEY_SIZE(256)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .mode_i(mode_i),
    .key_i(key_i), .valid_o(valid_o), .ready_i(ready_i), .round_key_o(round_key_o),
    .nr_o(nr_o), .err_o(err_o)
  );

  key_schedule_rt #(.MAX_KEY_SIZE(128)) dut128 (
    .clk(clk), .rst_n(rst_n), .valid_i(b_valid), .ready_o(b_ready), .mode_i(b_mode),
    .key_i(b_key), .valid_o(b_valid_o), .ready_i(b_ready_i), .round_key_o(b_rk),
    .nr_o(b_nr), .err_o(b_err)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] sbox_m [256];
  int exp_lat [3] = '{40, 46, 52};

  localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sbox_m[v[31:24]], sbox_m[v[23:16]], sbox_m[v[15:8]], sbox_m[v[7:0]]};
  endfunction

  function automatic logic [14:0][127:0] model_expand(input int m, input logic [255:0] key);
    logic [31:0] w [60];
    logic [14:0][127:0] rk;
    logic [31:0] t;
    logic [7:0] rc;
    int nk, nr;
    nk = 4 + 2 * m;
    nr = nk + 6;
    rc = 8'h01;
    rk = '0;
    for (int i = 0; i < 60; i++) begin
      if (i < nk) w[i] = key[255 - 32 * i -: 32];
      else        w[i] = 32'h0;
    end
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) rk[j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
    return rk;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int q = 0; q < 8; q++) k[32 * q +: 32] = $urandom;
    return k;
  endfunction

  // Issue one request from a negedge; returns cycles from the accepting edge to valid_o
  task automatic run_req(input logic [1:0] m, input logic [255:0] k, input logic pre_ready,
                         output int lat);
    valid_i = 1'b1;
    mode_i  = m;
    key_i   = k;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    key_i   = ~k;
    if (pre_ready) ready_i = 1'b1;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ready_o, valid_o, err_o} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b want=100", {ready_o, valid_o, err_o});
    end
    checks++;
    if (nr_o !== 4'd0 || round_key_o !== '0) begin
      failures++;
      $display("FAIL reset_data nr got=%0d want=0 rk_nonzero=%0d", nr_o, round_key_o != '0);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips();
    logic [255:0] keys [3];
    logic [127:0] last_rk [3];
    int lat;
    logic [14:0][127:0] exp_rk;
    keys[0] = KEY_A1; keys[1] = KEY_A2; keys[2] = KEY_A3;
    last_rk[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    last_rk[1] = 128'he98ba06f448c773c8ecc720401002202;
    last_rk[2] = 128'hfe4890d1e6188d0b046df344706c631e;
    for (int m = 0; m < 3; m++) begin
      exp_rk = model_expand(m, keys[m]);
      run_req(2'(m), keys[m], 1'b0, lat);
      checks++;
      if (lat != exp_lat[m]) begin
        failures++;
        $display("FAIL fips_latency mode=%0d got=%0d want=%0d", m, lat, exp_lat[m]);
      end
      checks++;
      if (round_key_o[10 + 2 * m] !== last_rk[m]) begin
        failures++;
        $display("FAIL fips_last_rk mode=%0d got=%h want=%h", m, round_key_o[10 + 2 * m], last_rk[m]);
      end
      checks++;
      if (round_key_o !== exp_rk || nr_o !== 4'(10 + 2 * m) || ready_o !== 1'b0) begin
        failures++;
        $display("FAIL fips_full mode=%0d nr got=%0d want=%0d ready=%b", m, nr_o, 10 + 2 * m, ready_o);
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      checks++;
      if ({valid_o, ready_o} !== 2'b01) begin
        failures++;
        $display("FAIL fips_handshake mode=%0d got=%b want=01", m, {valid_o, ready_o});
      end
    end
  endtask

  task automatic test_random();
    int lat, m, hold;
    logic pre;
    logic [255:0] k;
    logic [14:0][127:0] exp_rk;
    for (int n = 0; n < 10; n++) begin
      m    = int'($urandom_range(0, 2));
      k    = rand_key();
      pre  = 1'($urandom_range(0, 1));
      hold = pre ? 0 : int'($urandom_range(0, 3));
      exp_rk = model_expand(m, k);
      run_req(2'(m), k, pre, lat);
      checks++;
      if (lat != exp_lat[m] || round_key_o !== exp_rk || nr_o !== 4'(10 + 2 * m)) begin
        failures++;
        $display("FAIL rand_result n=%0d mode=%0d lat got=%0d want=%0d nr got=%0d rk_ok=%0d",
                 n, m, lat, exp_lat[m], nr_o, round_key_o === exp_rk);
      end
      for (int h = 0; h < hold; h++) @(negedge clk);
      checks++;
      if (valid_o !== 1'b1 || round_key_o !== exp_rk) begin
        failures++;
        $display("FAIL rand_hold n=%0d valid got=%b want=1", n, valid_o);
      end
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      checks++;
      if ({valid_o, ready_o} !== 2'b01) begin
        failures++;
        $display("FAIL rand_release n=%0d pre=%0d got=%b want=01", n, pre, {valid_o, ready_o});
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int modes [3] = '{2, 0, 1};
    logic [255:0] k;
    for (int n = 0; n < 3; n++) begin
      k = rand_key();
      checks++;
      if (ready_o !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready n=%0d got=%b want=1", n, ready_o);
      end
      run_req(2'(modes[n]), k, 1'b1, lat);
      checks++;
      if (lat != exp_lat[modes[n]] || round_key_o !== model_expand(modes[n], k)) begin
        failures++;
        $display("FAIL b2b_result n=%0d lat got=%0d want=%0d", n, lat, exp_lat[modes[n]]);
      end
      @(negedge clk);
      ready_i = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [255:0] k;
    logic [14:0][127:0] exp_rk;
    k = rand_key();
    exp_rk = model_expand(2, k);
    run_req(2'd2, k, 1'b0, lat);
    for (int c = 0; c < 20; c++) begin
      valid_i = 1'(c % 2);
      mode_i  = 2'(c % 4);
      @(negedge clk);
      checks++;
      if ({valid_o, ready_o, err_o, nr_o} !== {3'b100, 4'd14} || round_key_o !== exp_rk) begin
        failures++;
        $display("FAIL bp_hold c=%0d flags got=%b want=100 nr got=%0d want=14",
                 c, {valid_o, ready_o, err_o}, nr_o);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    checks++;
    if ({valid_o, ready_o, err_o} !== 3'b010) begin
      failures++;
      $display("FAIL bp_release got=%b want=010", {valid_o, ready_o, err_o});
    end
  endtask

  task automatic test_errors();
    int lat;
    valid_i = 1'b1;
    mode_i  = 2'd3;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if ({err_o, ready_o} !== 2'b11) begin
      failures++;
      $display("FAIL err_rsvd got=%b want=11", {err_o, ready_o});
    end
    @(negedge clk);
    checks++;
    if ({err_o, ready_o, valid_o} !== 3'b010) begin
      failures++;
      $display("FAIL err_rsvd_pulse got=%b want=010", {err_o, ready_o, valid_o});
    end
    for (int m = 1; m < 3; m++) begin
      b_valid = 1'b1;
      b_mode  = 2'(m);
      @(posedge clk);
      @(negedge clk);
      b_valid = 1'b0;
      checks++;
      if ({b_err, b_ready} !== 2'b11) begin
        failures++;
        $display("FAIL err_size mode=%0d got=%b want=11", m, {b_err, b_ready});
      end
      @(negedge clk);
      checks++;
      if ({b_err, b_ready} !== 2'b01) begin
        failures++;
        $display("FAIL err_size_pulse mode=%0d got=%b want=01", m, {b_err, b_ready});
      end
    end
    b_valid = 1'b1;
    b_mode  = 2'd0;
    b_key   = KEY_A1;
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    lat = 0;
    while (b_valid_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 40 || b_rk !== model_expand(0, KEY_A1) || b_nr !== 4'd10 || b_err !== 1'b0) begin
      failures++;
      $display("FAIL small_accept lat got=%0d want=40 nr got=%0d want=10", lat, b_nr);
    end
    b_ready_i = 1'b1;
    @(negedge clk);
    b_ready_i = 1'b0;
  endtask

  task automatic test_abort();
    int lat, seen;
    valid_i = 1'b1;
    mode_i  = 2'd2;
    key_i   = KEY_A3;
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 1; c < 20; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, err_o} !== 3'b100 || nr_o !== 4'd0 || round_key_o !== '0) begin
      failures++;
      $display("FAIL abort_reset flags got=%b want=100 nr got=%0d want=0", {ready_o, valid_o, err_o}, nr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (valid_o !== 1'b0 || ready_o !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_quiet got=%0d bad cycles want=0", seen);
    end
    run_req(2'd0, KEY_A1, 1'b0, lat);
    checks++;
    if (lat != 40 || round_key_o[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || nr_o !== 4'd10) begin
      failures++;
      $display("FAIL abort_rerun lat got=%0d want=40 rk10 got=%h", lat, round_key_o[10]);
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
